// File: rtl/add_seq_wide.sv
// add_seq_wide: multi-cycle 16*WORDS-bit adder sequencer around an external 16-bit ripple adder.
// Operands are added one word per cycle, LSW first, with the carry chained through a register.
module add_seq_wide #(
    parameter int unsigned WORDS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                op_cin,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_sum,
    input  logic                add_cout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_ovf
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic                 carry;
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic [W-1:0]         res;
    logic                 cout_reg;
    logic                 ovf_reg;
    logic [$clog2(W)-1:0] base;

    // Bit offset of the current word: idx * 16.
    assign base = {idx, 4'b0000};

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[base +: 16];
            add_b   = b_reg[base +: 16];
            add_cin = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            res      <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        carry <= op_cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[base +: 16] <= add_sum;
                    carry           <= add_cout;
                    if (idx == LAST) begin
                        // Overflow uses the MSW adder output; only registered copies reach out_*.
                        idx      <= '0;
                        state    <= DONE;
                        cout_reg <= add_cout;
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[15] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_sum  = res;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_add_seq_wide.sv
// Testbench for add_seq_wide (WORDS=2) with a behavioural 16-bit adder and a result scoreboard.
module tb_add_seq_wide;
    localparam int unsigned WORDS = 2;
    localparam int unsigned W     = 16 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [15:0]  add_a;
    logic [15:0]  add_b;
    logic         add_cin;
    logic [15:0]  add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int   tests;
    int   fails;
    exp_t sb[$];

    add_seq_wide #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    // External ripple adder stand-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Present one request in IDLE, record its expected result, and return just after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        sb.push_back(model(a, b, cin));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        op_cin   = 1'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin} !==
            {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b a=%h b=%h cin=%b, want rdy=1 vld=0 all else 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [4] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [W-1:0] vb [4] = '{32'h00000001, 32'h00000000, 32'h00000001, 32'h80000000};
        logic         vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            start_op(va[i], vb[i], vc[i]);
            tests++;
            if ({add_a, add_b, add_cin} !== {va[i][15:0], vb[i][15:0], vc[i]}) begin
                fails++;
                $display("FAIL basic_lsw_drive[%0d]: got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                         i, add_a, add_b, add_cin, va[i][15:0], vb[i][15:0], vc[i]);
            end
            wait_valid(n);
            tests++;
            if (n !== int'(WORDS)) begin
                fails++;
                $display("FAIL basic_latency[%0d]: got %0d edges want %0d", i, n, WORDS);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                tests++;
                if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, e.sum, e.cout, e.ovf}) begin
                    fails++;
                    $display("FAIL basic_result[%0d]: got vld=%b sum=%h cout=%b ovf=%b want vld=1 sum=%h cout=%b ovf=%b",
                             i, out_valid, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            tests++;
            if ({out_valid, in_ready} !== 2'b01) begin
                fails++;
                $display("FAIL basic_release[%0d]: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        exp_t e;
        start_op(32'h0001_2345, 32'h0000_ABCD, 1'b0);
        wait_valid(n);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            op_a     = $urandom;
            op_b     = $urandom;
            @(posedge clk); #1;
            tests++;
            if ({out_valid, in_ready, out_sum, out_cout, out_ovf} !== {1'b1, 1'b0, e.sum, e.cout, e.ovf}) begin
                fails++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b sum=%h cout=%b ovf=%b want vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                         i, out_valid, in_ready, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL no_stray_accept[%0d]: got out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        exp_t e;
        start_op(32'hAAAA_5555, 32'h1234_4321, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        tests++;
        if ({in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin} !==
            {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sum=%h cout=%b ovf=%b a=%h b=%h cin=%b, want rdy=1 vld=0 all else 0",
                     in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_discard[%0d]: got out_valid=%b want 0", i, out_valid);
            end
        end
        start_op(32'h12345678, 32'h11111111, 1'b0);
        wait_valid(n);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, e.sum, e.cout, e.ovf} || out_sum !== 32'h23456789) begin
                fails++;
                $display("FAIL after_reset_op: got vld=%b sum=%h cout=%b ovf=%b want vld=1 sum=23456789 cout=0 ovf=0",
                         out_valid, out_sum, out_cout, out_ovf);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int unsigned sent;
        int unsigned recv;
        int unsigned cyc;
        int unsigned last_acc;
        bit have_last;
        bit acc;
        exp_t e;
        sent = 0; recv = 0; cyc = 0; last_acc = 0; have_last = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        op_a      = $urandom;
        op_b      = $urandom;
        op_cin    = 1'($urandom);
        in_valid  = 1'b1;
        while (recv < 100 && cyc < 2000) begin
            acc = in_valid && in_ready;
            if (acc) begin
                sb.push_back(model(op_a, op_b, op_cin));
                sent++;
                if (have_last) begin
                    tests++;
                    if (cyc - last_acc != WORDS + 2) begin
                        fails++;
                        $display("FAIL b2b_interval[%0d]: got %0d cycles want %0d", sent, cyc - last_acc, WORDS + 2);
                    end
                end
                have_last = 1'b1;
                last_acc  = cyc;
            end
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_unexpected: got result sum=%h with nothing outstanding, want none", out_sum);
                end else begin
                    e = sb.pop_front();
                    if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf}) begin
                        fails++;
                        $display("FAIL b2b_result[%0d]: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                 recv, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                op_a   = $urandom;
                op_b   = $urandom;
                op_cin = 1'($urandom);
            end
            in_valid = (sent < 100);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (recv != 100) begin
            fails++;
            $display("FAIL b2b_count: got %0d results want 100", recv);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
